// File: rtl/aes_pkg.sv
// Shared AES decryption-path types: column/state words, column indexing helpers and FSM encodings.
// Column 0 lives in the most significant 32 bits of a state; that mapping is defined only here.
package aes_pkg;

    localparam int AES_NCOLS = 4;

    typedef logic [31:0]  col_t;
    typedef logic [127:0] state_t;
    typedef logic [1:0]   col_idx_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MIX  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic col_t get_col(input state_t s, input col_idx_t idx);
        return s[(AES_NCOLS - 1 - int'(idx)) * 32 +: 32];
    endfunction

    function automatic state_t put_col(input state_t s, input col_idx_t idx, input col_t c);
        state_t r;
        r = s;
        r[(AES_NCOLS - 1 - int'(idx)) * 32 +: 32] = c;
        return r;
    endfunction

endpackage

// File: rtl/reverse_mix_cols.sv
// Combinational InvMixColumns on one 32-bit column (byte 0 in the top byte).
// Zero latency; no flow control.
module reverse_mix_cols
    import aes_pkg::*;
(
    input  col_t input_col,
    output col_t final_col
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] m11(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] m13(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] m14(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    logic [7:0] a0, a1, a2, a3;

    assign a0 = input_col[31:24];
    assign a1 = input_col[23:16];
    assign a2 = input_col[15:8];
    assign a3 = input_col[7:0];

    assign final_col[31:24] = m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3);
    assign final_col[23:16] = m9(a0)  ^ m14(a1) ^ m11(a2) ^ m13(a3);
    assign final_col[15:8]  = m13(a0) ^ m9(a1)  ^ m14(a2) ^ m11(a3);
    assign final_col[7:0]   = m11(a0) ^ m13(a1) ^ m9(a2)  ^ m14(a3);

endmodule

// File: rtl/inv_round_col_engine.sv
// AddRoundKey then InvMixColumns one column per cycle through a shared column block; 4 column cycles after load.
// Accepts only when idle; result is held in DONE until out_ready, with a one-cycle bubble before the next accept.
module inv_round_col_engine
    import aes_pkg::*;
#(
    parameter int NCOLS = AES_NCOLS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    input  logic         bypass_mix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int CW = $clog2(NCOLS);
    localparam logic [CW-1:0] LAST_COL = CW'(NCOLS - 1);

    logic [1:0]    st_q, st_d;
    state_t        buf_q, buf_d;
    logic [CW-1:0] col_q, col_d;
    col_t          mix_in, mix_out;

    assign mix_in = get_col(buf_q, col_q);

    reverse_mix_cols u_mix (
        .input_col (mix_in),
        .final_col (mix_out)
    );

    always_comb begin
        st_d  = st_q;
        buf_d = buf_q;
        col_d = col_q;
        case (st_q)
            ST_IDLE: begin
                if (in_valid) begin
                    buf_d = state_in ^ key_in;
                    col_d = '0;
                    st_d  = bypass_mix ? ST_DONE : ST_MIX;
                end
            end
            ST_MIX: begin
                buf_d = put_col(buf_q, col_q, mix_out);
                // Counter parks on the last column; the next accept rewinds it.
                if (col_q == LAST_COL) begin
                    st_d = ST_DONE;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    st_d = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q  <= ST_IDLE;
            buf_q <= '0;
            col_q <= '0;
        end else begin
            st_q  <= st_d;
            buf_q <= buf_d;
            col_q <= col_d;
        end
    end

    assign in_ready  = (st_q == ST_IDLE);
    assign out_valid = (st_q == ST_DONE);
    assign busy      = (st_q != ST_IDLE);
    assign state_out = buf_q;

endmodule
